// File: rtl/adc_sample_scheduler.sv
// Paces ADC convert strobes at a programmable period, tracking conversion
// completion, finite/continuous bursts and overruns.
module adc_sample_scheduler #(
  parameter int CNT_W      = 32,
  parameter int BURST_W    = 16,
  parameter int OVR_W      = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               adc_busy,
  input  logic               adc_done,
  output logic               conv_start,
  output logic               running,
  output logic               done,
  output logic [CNT_W-1:0]   sample_count,
  output logic               overrun,
  output logic [OVR_W-1:0]   overrun_count,
  output logic [CNT_W-1:0]   period_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   samples_q, samples_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] issued_q, issued_d;
  logic [OVR_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic               ovr_q, ovr_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   period_clamped;
  logic               tick;
  logic               done_ok;

  assign period_clamped = (period_in < MIN_P) ? MIN_P : period_in;
  assign tick           = (state_q == RUN) && (cnt_q == '0);
  assign done_ok        = pending_q && adc_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    samples_d  = samples_q;
    burst_d    = burst_q;
    issued_d   = issued_q;
    ovr_cnt_d  = ovr_cnt_q;
    ovr_d      = ovr_q;
    pending_d  = pending_q;
    done_d     = 1'b0;
    conv_start = 1'b0;

    if (!enable) begin
      // Abort: drop any outstanding conversion so a late adc_done is ignored.
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d   = RUN;
            samples_d = '0;
            ovr_cnt_d = '0;
            ovr_d     = 1'b0;
            issued_d  = '0;
            pending_d = 1'b0;
            period_d  = period_clamped;
            burst_d   = burst_len;
            cnt_d     = '0;
          end
        end
        RUN: begin
          // Completion is handled before the tick so a coincident tick can issue.
          if (done_ok) begin
            pending_d = 1'b0;
            samples_d = samples_q + CNT_W'(1);
          end
          if (stop) begin
            state_d = DRAIN;
          end else begin
            if (tick) begin
              period_d = period_clamped;
              cnt_d    = period_clamped - CNT_W'(1);
              if (pending_d || adc_busy) begin
                ovr_d = 1'b1;
                if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
              end else begin
                conv_start = 1'b1;
                pending_d  = 1'b1;
                issued_d   = issued_q + BURST_W'(1);
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
            if ((burst_q != '0) && (issued_d == burst_q)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (done_ok) begin
            pending_d = 1'b0;
            samples_d = samples_q + CNT_W'(1);
          end
          if (!pending_d) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      samples_q <= '0;
      burst_q   <= '0;
      issued_q  <= '0;
      ovr_cnt_q <= '0;
      ovr_q     <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      samples_q <= samples_d;
      burst_q   <= burst_d;
      issued_q  <= issued_d;
      ovr_cnt_q <= ovr_cnt_d;
      ovr_q     <= ovr_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign running       = (state_q != IDLE);
  assign done          = done_q;
  assign sample_count  = samples_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;
  assign period_active = period_q;

endmodule
